// File: rtl/rs_muldiv_station_if.sv
// Dispatch, CDB and issue signals of one mul/div reservation station.
// master = dispatch/CDB/FU side, slave = the station itself.
interface rs_muldiv_station_if #(
  parameter int CNT_W = 3
);
  logic             rs_on;
  logic [31:0]      in_operand1;
  logic [31:0]      in_operand2;
  logic [2:0]       in_func3;
  logic [31:0]      in_pc;
  logic [7:0]       rd_phy_reg;
  logic [7:0]       Operand1_phy;
  logic [7:0]       Operand2_phy;
  logic [1:0]       valid;
  logic [31:0]      inst_num;
  logic             cdb_valid;
  logic [7:0]       cdb_phy_reg;
  logic [31:0]      cdb_data;
  logic             flush;
  logic             issue_ready;
  logic             issue_valid;
  logic [31:0]      issue_operand1;
  logic [31:0]      issue_operand2;
  logic [2:0]       issue_func3;
  logic [31:0]      issue_pc;
  logic [7:0]       issue_rd_phy_reg;
  logic [31:0]      issue_inst_num;
  logic             rs_full;
  logic [CNT_W-1:0] rs_count;
  logic             dispatch_drop;

  modport master (
    output rs_on, in_operand1, in_operand2, in_func3, in_pc, rd_phy_reg,
           Operand1_phy, Operand2_phy, valid, inst_num,
           cdb_valid, cdb_phy_reg, cdb_data, flush, issue_ready,
    input  issue_valid, issue_operand1, issue_operand2, issue_func3, issue_pc,
           issue_rd_phy_reg, issue_inst_num, rs_full, rs_count, dispatch_drop
  );

  modport slave (
    input  rs_on, in_operand1, in_operand2, in_func3, in_pc, rd_phy_reg,
           Operand1_phy, Operand2_phy, valid, inst_num,
           cdb_valid, cdb_phy_reg, cdb_data, flush, issue_ready,
    output issue_valid, issue_operand1, issue_operand2, issue_func3, issue_pc,
           issue_rd_phy_reg, issue_inst_num, rs_full, rs_count, dispatch_drop
  );
endinterface

// File: rtl/rs_muldiv_station.sv
// In-order-compacted reservation station for one mul/div lane: captures dispatched
// entries, wakes operands from the CDB and offers the oldest ready entry to the FU.
module rs_muldiv_station #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic            clk,
  input logic            reset,
  rs_muldiv_station_if.slave io_rs
);

  typedef struct packed {
    logic        busy;
    logic        rdy1;
    logic        rdy2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [7:0]  tag1;
    logic [7:0]  tag2;
    logic [2:0]  func3;
    logic [31:0] pc;
    logic [7:0]  rd;
    logic [31:0] inst;
  } slot_t;

  slot_t            r_slot [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_drop;

  slot_t            w_shf [DEPTH];
  slot_t            w_dsp [DEPTH];
  slot_t            w_nxt [DEPTH];
  slot_t            w_new;
  logic [DEPTH-1:0] w_shift;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;
  logic             w_found;
  logic             w_full;
  logic             w_do_issue;
  logic             w_do_disp;
  logic [CNT_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_iss_op1;
  logic [31:0]      w_iss_op2;
  logic [2:0]       w_iss_func3;
  logic [31:0]      w_iss_pc;
  logic [7:0]       w_iss_rd;
  logic [31:0]      w_iss_inst;

  // Oldest-ready select; w_shift marks the selected slot and everything above it.
  always_comb begin
    w_found     = 1'b0;
    w_shift     = '0;
    w_iss_op1   = 32'd0;
    w_iss_op2   = 32'd0;
    w_iss_func3 = 3'd0;
    w_iss_pc    = 32'd0;
    w_iss_rd    = 8'd0;
    w_iss_inst  = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && r_slot[i].busy && r_slot[i].rdy1 && r_slot[i].rdy2) begin
        w_found     = 1'b1;
        w_iss_op1   = r_slot[i].op1;
        w_iss_op2   = r_slot[i].op2;
        w_iss_func3 = r_slot[i].func3;
        w_iss_pc    = r_slot[i].pc;
        w_iss_rd    = r_slot[i].rd;
        w_iss_inst  = r_slot[i].inst;
      end else begin
        w_found = w_found;
      end
      w_shift[i] = w_found;
    end
  end

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_do_issue = w_found & io_rs.issue_ready;
  assign w_do_disp  = io_rs.rs_on & ~w_full;
  assign w_wr_idx   = r_count - CNT_W'(w_do_issue);
  assign w_cnt_nxt  = w_wr_idx + CNT_W'(w_do_disp);

  assign w_new = '{busy: 1'b1, rdy1: io_rs.valid[1], rdy2: io_rs.valid[0],
                   op1: io_rs.in_operand1, op2: io_rs.in_operand2,
                   tag1: io_rs.Operand1_phy, tag2: io_rs.Operand2_phy,
                   func3: io_rs.in_func3, pc: io_rs.in_pc,
                   rd: io_rs.rd_phy_reg, inst: io_rs.inst_num};

  // Next slot contents: compact out the issued slot, append the dispatch, then wake.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_shf[i] = (w_do_issue && w_shift[i]) ? r_slot[i+1] : r_slot[i];
    end
    w_shf[DEPTH-1] = w_do_issue ? slot_t'('0) : r_slot[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      w_dsp[i]  = (w_do_disp && (CNT_W'(i) == w_wr_idx)) ? w_new : w_shf[i];
      w_hit1[i] = io_rs.cdb_valid && w_dsp[i].busy && !w_dsp[i].rdy1 &&
                  (w_dsp[i].tag1 == io_rs.cdb_phy_reg);
      w_hit2[i] = io_rs.cdb_valid && w_dsp[i].busy && !w_dsp[i].rdy2 &&
                  (w_dsp[i].tag2 == io_rs.cdb_phy_reg);
      w_nxt[i]      = w_dsp[i];
      w_nxt[i].rdy1 = w_dsp[i].rdy1 | w_hit1[i];
      w_nxt[i].rdy2 = w_dsp[i].rdy2 | w_hit2[i];
      w_nxt[i].op1  = w_hit1[i] ? io_rs.cdb_data : w_dsp[i].op1;
      w_nxt[i].op2  = w_hit2[i] ? io_rs.cdb_data : w_dsp[i].op2;
    end
  end

  // Slot storage and occupancy; flush behaves like reset for the entries.
  always_ff @(posedge clk) begin
    if (!reset || io_rs.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= w_nxt[i];
      end
      r_count <= w_cnt_nxt;
    end
  end

  // Refused-dispatch pulse, judged against the pre-edge full flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= io_rs.rs_on & w_full;
    end
  end

  assign io_rs.issue_valid      = w_found;
  assign io_rs.issue_operand1   = w_iss_op1;
  assign io_rs.issue_operand2   = w_iss_op2;
  assign io_rs.issue_func3      = w_iss_func3;
  assign io_rs.issue_pc         = w_iss_pc;
  assign io_rs.issue_rd_phy_reg = w_iss_rd;
  assign io_rs.issue_inst_num   = w_iss_inst;
  assign io_rs.rs_full          = w_full;
  assign io_rs.rs_count         = r_count;
  assign io_rs.dispatch_drop    = r_drop;

endmodule
